// File: rtl/coco_kbd_pkg.sv
// coco_kbd_pkg: shared types and scancode constants for the CoCo keyboard matrix
package coco_kbd_pkg;
    localparam int ROWS = 7;
    localparam int COLS = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    function automatic key_pos_t kp(input int r, input int c);
        return '{1'b1, 3'(r), 3'(c)};
    endfunction
endpackage

// File: rtl/coco_kbd_xlate.sv
// coco_kbd_xlate: combinational set-2 {extended, scancode} to CoCo matrix position
module coco_kbd_xlate
    import coco_kbd_pkg::*;
(
    input  logic       i_ext,
    input  logic [7:0] i_code,
    output key_pos_t   o_pos
);
    always_comb begin
        o_pos = '0;
        case ({i_ext, i_code})
            9'h054: o_pos = kp(0, 0);
            9'h01C: o_pos = kp(0, 1);
            9'h032: o_pos = kp(0, 2);
            9'h021: o_pos = kp(0, 3);
            9'h023: o_pos = kp(0, 4);
            9'h024: o_pos = kp(0, 5);
            9'h02B: o_pos = kp(0, 6);
            9'h034: o_pos = kp(0, 7);
            9'h033: o_pos = kp(1, 0);
            9'h043: o_pos = kp(1, 1);
            9'h03B: o_pos = kp(1, 2);
            9'h042: o_pos = kp(1, 3);
            9'h04B: o_pos = kp(1, 4);
            9'h03A: o_pos = kp(1, 5);
            9'h031: o_pos = kp(1, 6);
            9'h044: o_pos = kp(1, 7);
            9'h04D: o_pos = kp(2, 0);
            9'h015: o_pos = kp(2, 1);
            9'h02D: o_pos = kp(2, 2);
            9'h01B: o_pos = kp(2, 3);
            9'h02C: o_pos = kp(2, 4);
            9'h03C: o_pos = kp(2, 5);
            9'h02A: o_pos = kp(2, 6);
            9'h01D: o_pos = kp(2, 7);
            9'h022: o_pos = kp(3, 0);
            9'h035: o_pos = kp(3, 1);
            9'h01A: o_pos = kp(3, 2);
            9'h175: o_pos = kp(3, 3);
            9'h172: o_pos = kp(3, 4);
            9'h16B: o_pos = kp(3, 5);
            9'h174: o_pos = kp(3, 6);
            9'h029: o_pos = kp(3, 7);
            9'h045: o_pos = kp(4, 0);
            9'h016: o_pos = kp(4, 1);
            9'h01E: o_pos = kp(4, 2);
            9'h026: o_pos = kp(4, 3);
            9'h025: o_pos = kp(4, 4);
            9'h02E: o_pos = kp(4, 5);
            9'h036: o_pos = kp(4, 6);
            9'h03D: o_pos = kp(4, 7);
            9'h03E: o_pos = kp(5, 0);
            9'h046: o_pos = kp(5, 1);
            9'h052: o_pos = kp(5, 2);
            9'h04C: o_pos = kp(5, 3);
            9'h041: o_pos = kp(5, 4);
            9'h04E: o_pos = kp(5, 5);
            9'h049: o_pos = kp(5, 6);
            9'h04A: o_pos = kp(5, 7);
            {1'b0, SC_ENTER}:  o_pos = kp(6, 0);
            9'h16C:            o_pos = kp(6, 1);
            {1'b0, SC_ESC}:    o_pos = kp(6, 2);
            {1'b0, SC_LSHIFT}: o_pos = kp(6, 7);
            {1'b0, SC_RSHIFT}: o_pos = kp(6, 7);
            default:           o_pos = '0;
        endcase
    end
endmodule

// File: rtl/coco_kbd_matrix.sv
// coco_kbd_matrix: ps2_key events to CoCo 2 keyboard matrix with minimum key hold
module coco_kbd_matrix
    import coco_kbd_pkg::*;
#(
    parameter int HOLD_CYCLES = 1145440,
    parameter int CNT_W       = 21
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [10:0] i_ps2_key,
    input  logic [7:0]  i_col_n,
    input  logic        i_joy1_fire,
    input  logic        i_joy2_fire,
    output logic [6:0]  o_rows_n,
    output logic        o_key_event,
    output logic        o_any_key
);
    localparam int N = ROWS * COLS;

    logic [N-1:0]     r_matrix, r_pend, w_matrix, w_pend, w_bit, w_press, w_rel;
    logic [CNT_W-1:0] r_timer, w_timer;
    logic             r_tog, r_armed, r_lshift, r_rshift;
    logic             w_lshift, w_rshift, w_evt, w_shift, w_drain;
    logic [6:0]       w_rows_n;
    key_pos_t         w_pos;

    coco_kbd_xlate u_xlate (
        .i_ext  (i_ps2_key[8]),
        .i_code (i_ps2_key[7:0]),
        .o_pos  (w_pos)
    );

    always_comb begin
        w_evt    = r_armed && (i_ps2_key[10] != r_tog) && w_pos.valid;
        w_bit    = N'(1) << (w_pos.row * COLS + w_pos.col);
        w_shift  = (w_pos.row == 3'd6) && (w_pos.col == 3'd7);
        w_lshift = r_lshift;
        w_rshift = r_rshift;
        if (w_evt && w_shift && i_ps2_key[7:0] == SC_LSHIFT)
            w_lshift = i_ps2_key[9];
        if (w_evt && w_shift && i_ps2_key[7:0] == SC_RSHIFT)
            w_rshift = i_ps2_key[9];
        w_press  = (w_evt && i_ps2_key[9]) ? w_bit : '0;
        // the shared shift bit is only released once neither shift key is held
        w_rel    = (w_evt && !i_ps2_key[9] && !(w_shift && (w_lshift || w_rshift))) ? w_bit : '0;
        // timer at 1 expires this cycle, at 0 releases act at once; either way pending drains now
        w_drain  = r_timer <= CNT_W'(1);
        w_matrix = (w_drain ? r_matrix & ~(r_pend | w_rel) : r_matrix) | w_press;
        w_pend   = w_drain ? '0 : (r_pend | w_rel) & ~w_press;
        w_timer  = |w_press ? CNT_W'(HOLD_CYCLES) : (r_timer != '0 ? r_timer - 1'b1 : r_timer);
        w_rows_n = '1;
        for (int r = 0; r < ROWS; r++)
            w_rows_n[r] = ~|(r_matrix[r*COLS +: COLS] & ~i_col_n);
        if (i_joy1_fire)
            w_rows_n[0] = 1'b0;
        if (i_joy2_fire)
            w_rows_n[1] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_matrix    <= '0;
            r_pend      <= '0;
            r_timer     <= '0;
            r_tog       <= 1'b0;
            r_armed     <= 1'b0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            o_rows_n    <= '1;
            o_key_event <= 1'b0;
            o_any_key   <= 1'b0;
        end else begin
            r_matrix    <= w_matrix;
            r_pend      <= w_pend;
            r_timer     <= w_timer;
            r_tog       <= i_ps2_key[10];
            r_armed     <= 1'b1;
            r_lshift    <= w_lshift;
            r_rshift    <= w_rshift;
            o_rows_n    <= w_rows_n;
            o_key_event <= w_evt;
            o_any_key   <= |r_matrix;
        end
    end
endmodule

// File: tb/tb_coco_kbd_matrix.sv
// tb_coco_kbd_matrix: directed plus random stimulus against a key-level reference model
module tb_coco_kbd_matrix;
    localparam int H = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] ps2 = '0;
    logic [7:0]  col_n = '1;
    logic        j1 = 1'b0, j2 = 1'b0;
    logic [6:0]  rows_n;
    logic        kev, anyk;

    coco_kbd_matrix #(.HOLD_CYCLES(H), .CNT_W(6)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ps2_key   (ps2),
        .i_col_n     (col_n),
        .i_joy1_fire (j1),
        .i_joy2_fire (j2),
        .o_rows_n    (rows_n),
        .o_key_event (kev),
        .o_any_key   (anyk)
    );

    always #5 clk = ~clk;

    int         ncmp = 0, nfail = 0, cyc = 0, lp = -1000;
    bit         mat[7][8], pend[7][8];
    bit         lsh = 0, rsh = 0, ev = 0;
    logic [8:0] keymap[7][8];

    function automatic void lookup(input logic [8:0] k, output bit ok, output int r, output int c);
        ok = 0; r = 0; c = 0;
        if (k == 9'h059) begin
            ok = 1; r = 6; c = 7;
        end
        for (int rr = 0; rr < 7; rr++)
            for (int cc = 0; cc < 8; cc++)
                if (keymap[rr][cc] != 9'h000 && keymap[rr][cc] == k) begin
                    ok = 1; r = rr; c = cc;
                end
    endfunction

    // model the edge about to happen, then check what the DUT shows after it
    task automatic tick();
        logic [6:0] er;
        bit ee, ea, ok, skip;
        int r, c;
        er = '1; ee = 0; ea = 0;
        if (!rst_n) begin
            mat = '{default: 0}; pend = '{default: 0};
            lsh = 0; rsh = 0; lp = -1000;
        end else begin
            for (int i = 0; i < 7; i++)
                for (int k = 0; k < 8; k++) begin
                    if (mat[i][k] && !col_n[k]) er[i] = 1'b0;
                    if (mat[i][k]) ea = 1;
                end
            if (j1) er[0] = 1'b0;
            if (j2) er[1] = 1'b0;
            if (cyc == lp + H) begin
                for (int i = 0; i < 7; i++)
                    for (int k = 0; k < 8; k++)
                        if (pend[i][k]) mat[i][k] = 0;
                pend = '{default: 0};
            end
            lookup(ps2[8:0], ok, r, c);
            ee = ev && ok;
            if (ee) begin
                skip = 0;
                if (r == 6 && c == 7) begin
                    if (ps2[7:0] == 8'h12) lsh = ps2[9]; else rsh = ps2[9];
                    skip = !ps2[9] && (lsh || rsh);
                end
                if (ps2[9]) begin
                    mat[r][c] = 1; pend[r][c] = 0; lp = cyc;
                end else if (!skip) begin
                    if (cyc >= lp + H) mat[r][c] = 0; else pend[r][c] = 1;
                end
            end
        end
        ev = 0;
        @(posedge clk);
        #1;
        cyc++;
        ncmp++;
        assert (rows_n === er) else begin
            nfail++;
            $error("FAIL rows_n cyc=%0d got %h exp %h", cyc, rows_n, er);
        end
        ncmp++;
        assert (kev === ee) else begin
            nfail++;
            $error("FAIL key_event cyc=%0d got %b exp %b", cyc, kev, ee);
        end
        ncmp++;
        assert (anyk === ea) else begin
            nfail++;
            $error("FAIL any_key cyc=%0d got %b exp %b", cyc, anyk, ea);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic e, input logic [7:0] code, input logic p);
        ps2 = {~ps2[10], p, e, code};
        ev = 1;
        tick();
    endtask

    initial begin
        int r, c, gap;
        logic [8:0] k;
        keymap = '{
            '{9'h054, 9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034},
            '{9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044},
            '{9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D},
            '{9'h022, 9'h035, 9'h01A, 9'h175, 9'h172, 9'h16B, 9'h174, 9'h029},
            '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D},
            '{9'h03E, 9'h046, 9'h052, 9'h04C, 9'h041, 9'h04E, 9'h049, 9'h04A},
            '{9'h05A, 9'h16C, 9'h076, 9'h000, 9'h000, 9'h000, 9'h000, 9'h012}};
        repeat (4) begin
            ps2 = 11'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle(4);
        col_n = 8'hFD;
        send(0, 8'h1C, 1);
        idle(2);
        col_n = 8'hFE;
        idle(2);
        col_n = 8'h00;
        idle(H + 5);
        send(0, 8'h1C, 1);
        idle(9);
        send(0, 8'h1C, 0);
        idle(H + 5);
        send(0, 8'h1C, 1);
        idle(H + 5);
        send(0, 8'h1C, 0);
        idle(3);
        send(0, 8'h12, 1);
        send(0, 8'h59, 1);
        send(0, 8'h12, 0);
        idle(H + 5);
        col_n = 8'h7F;
        idle(2);
        send(0, 8'h59, 0);
        idle(H + 5);
        col_n = 8'hF7;
        send(1, 8'h75, 1);
        idle(3);
        send(1, 8'h75, 0);
        idle(H + 5);
        send(0, 8'h75, 1);
        idle(3);
        col_n = 8'hFF;
        j2 = 1'b1;
        idle(3);
        j2 = 1'b0;
        col_n = 8'h00;
        send(0, 8'h1C, 1);
        idle(3);
        send(0, 8'h1C, 0);
        idle(5);
        rst_n = 1'b0;
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        send(0, 8'h1C, 1);
        idle(2);
        send(0, 8'h1C, 0);
        idle(H + 5);
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 6);
            c = $urandom_range(0, 7);
            k = keymap[r][c];
            if (k == 9'h000 || $urandom_range(0, 7) == 0)
                k = 9'($urandom);
            else if (k == 9'h012 && $urandom_range(0, 1) == 1)
                k = 9'h059;
            send(k[8], k[7:0], 1'($urandom));
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            repeat (gap) begin
                col_n = 8'($urandom);
                j1 = ($urandom_range(0, 7) == 0);
                j2 = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/coco_kbd_matrix.md
Name: coco_kbd_matrix

Overview:
- Converts MiSTer ps2_key events into the CoCo 2 keyboard matrix (7 rows × 8 columns) read by the PIA keyboard scan inside po8.
- Sits between hps_io ps2_key and po8. Drives the active-low row returns for the column strobe that the PIA writes.
- Merges joystick fire buttons into rows 0/1.
- Enforces a minimum key hold, so a fast tap is never missed by the 60 Hz ROM scan.

Parameters:
- HOLD_CYCLES, 1145440: minimum clk cycles between the latest press and any release taking effect (20 ms at 57.272 MHz).
- CNT_W, 21: hold timer width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock (57.272 MHz)
- reset  in  1  asynchronous, active-low reset
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] set-2 scancode
- col_n  in  8  PIA PB column strobe, active low
- joy1_fire  in  1  right joystick fire, active high
- joy2_fire  in  1  left joystick fire, active high
- rows_n  out  7  PIA PA[6:0] row returns, active low
- key_event  out  1  one-cycle pulse per accepted (mapped) ps2 event
- any_key  out  1  high while any matrix bit is set

Behaviour:
- Reset (reset=0): key matrix=0, pending_release=0, timer=0, lshift=rshift=0, toggle latch=ps2_key[10] sampled on the first clk after deassert, rows_n=7'h7F, key_event=0, any_key=0.
- Event detection: an event is ps2_key[10] differing from the registered latch. Latch updates each cycle. Only one event per cycle is possible.
- Lookup: {extended, scancode} maps to (row, col, valid) via the sub-module. Unmapped codes produce no state change and no key_event.
- Map, rows 0–5:
  - row0: @=[54] A–G (col0–7)
  - row1: H–O
  - row2: P–W
  - row3: X Y Z UP(E0 75) DOWN(E0 72) LEFT(E0 6B) RIGHT(E0 74) SPACE(29)
  - row4: 0–7
  - row5: 8 9 :=[52] ;=[4C] ,=[41] -=[4E] .=[49] /=[4A]
- Map, row6: ENTER(5A)=c0, CLEAR(E0 6C)=c1, BREAK(76)=c2, SHIFT=c7 (12 or 59).
- Shift: lshift/rshift tracked separately. The matrix shift bit = lshift|rshift.
- Press event: set the matrix bit, clear its pending_release bit, load timer=HOLD_CYCLES.
- Release event: if timer==0, clear the matrix bit immediately. Otherwise set its pending_release bit.
- Timer: decrements to 0 and saturates. On the cycle it reaches 0, matrix &= ~pending_release and pending_release clears.
- Simultaneous press event and timer expiry: expiry applies first, then the press reloads the timer. A pressed key never loses its bit in the same cycle.
- Release of a key not held: sets its pending bit harmlessly. The bit is already 0 after expiry.
- Row output, registered, latency 1 clk from col_n/matrix change: rows_n[r] = ~(|(matrix[r] & ~col_n)).
- Joystick: joy1_fire forces rows_n[0]=0 and joy2_fire forces rows_n[1]=0, regardless of col_n, on the same registered stage.
- key_event asserts the cycle after the detected toggle. any_key = |matrix, registered.
- Ghosting is not modelled. Multi-key presses are independent bits.

Decomposition:
- Package coco_kbd_pkg:
  - ROWS=7, COLS=8
  - typedef key_pos_t {valid, row[2:0], col[2:0]}
  - localparams for the special scancodes (SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_ESC=8'h76, SC_ENTER=8'h5A)
- Sub-module coco_kbd_xlate: purely combinational {ext, code} → key_pos_t case table.
- All state (toggle latch, matrix, pending mask, timer, shift flags) lives in coco_kbd_matrix.

Test Plan:
- Reset held low with ps2_key random → rows_n=7F, any_key=0. Release reset and leave ps2_key static → no key_event.
- Press A (1C, toggle) with col_n=FD → rows_n=7E after 1 clk, key_event single pulse. col_n=FE → rows_n=7F.
- Press then release A 10 cycles apart with col_n=00 → rows_n[0] stays 0 until exactly HOLD_CYCLES after the press, then 7F. Repeat with the release issued after the timer has expired → clear in 1 clk.
- Press LSHIFT and RSHIFT, release LSHIFT, wait past hold, col_n=7F → rows_n[6]=0. Release RSHIFT, wait past hold → rows_n=7F.
- Extended UP (E0 75) with col_n=F7 → rows_n=77. Non-extended 75 (keypad 8) → unmapped, no key_event, rows_n=7F.
- joy2_fire=1 with col_n=FF → rows_n=7D. Assert reset mid-hold with A pending release → rows_n=7F, matrix and pending cleared; after deassert a new A press works normally.
